// File: rtl/rank_pkg.sv
`default_nettype none
// rank_pkg: shared encodings and width helpers for the rank dispatch front end.
// Rev 1.0
package rank_pkg;

   localparam int INVALID_REMAP = 0;
   localparam int INVALID_DROP  = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int in_fifo_width(input int code_bits, input int meta_w,
                                        input int flow_w, input int weight_w);
      return code_bits + meta_w + flow_w + weight_w;
   endfunction

   function automatic int out_fifo_width(input int rank_w, input int meta_w);
      return rank_w + meta_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rank_fifo.sv
`default_nettype none
// rank_fifo: fallthrough FIFO with occupancy count and registered nearly-full flag.
// Rev 1.0
module rank_fifo #(
   parameter int WIDTH    = 8,
   parameter int L2_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             nearly_full
);

   localparam int DEPTH = 1 << L2_DEPTH;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [L2_DEPTH-1:0] wr_ptr;
   logic [L2_DEPTH-1:0] rd_ptr;
   logic [L2_DEPTH:0]   count;
   logic [L2_DEPTH:0]   count_nxt;
   logic                full;
   logic                do_push;
   logic                do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (L2_DEPTH+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + (L2_DEPTH+1)'(1);
         2'b01:   count_nxt = count - (L2_DEPTH+1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         nearly_full <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + L2_DEPTH'(1);
         if (do_pop)  rd_ptr <= rd_ptr + L2_DEPTH'(1);
         count       <= count_nxt;
         nearly_full <= (count_nxt >= (L2_DEPTH+1)'(DEPTH - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Head is forced to zero when empty so stale storage never reaches the outputs.
   assign dout = empty ? '0 : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/rank_dispatch.sv
`default_nettype none
// rank_dispatch: steers descriptors to rank-op engines and collects their results
// round-robin into an output FIFO for the PIFO. Rev 1.0
module rank_dispatch #(
   parameter int NUM_RANK_OPS      = 4,
   parameter int RANK_CODE_BITS    = 4,
   parameter int FLOW_ID_WIDTH     = 16,
   parameter int FLOW_WEIGHT_WIDTH = 8,
   parameter int RANK_WIDTH        = 16,
   parameter int META_WIDTH        = 16,
   parameter int L2_DEPTH          = 4,
   parameter int INVALID_OP_MODE   = 0,
   parameter int DEFAULT_OP        = 0
) (
   input  logic                                 clk,
   input  logic                                 rst,
   output logic                                 busy,
   input  logic                                 insert,
   input  logic [META_WIDTH-1:0]                meta_in,
   input  logic [RANK_CODE_BITS-1:0]            rank_op_in,
   input  logic [FLOW_ID_WIDTH-1:0]             flowID_in,
   input  logic [FLOW_WEIGHT_WIDTH-1:0]         flow_weight_in,
   input  logic [NUM_RANK_OPS-1:0]              op_busy,
   output logic [NUM_RANK_OPS-1:0]              op_insert,
   output logic [META_WIDTH-1:0]                op_meta,
   output logic [FLOW_ID_WIDTH-1:0]             op_flowID,
   output logic [FLOW_WEIGHT_WIDTH-1:0]         op_flow_weight,
   input  logic [NUM_RANK_OPS-1:0]              op_valid_out,
   input  logic [NUM_RANK_OPS*RANK_WIDTH-1:0]   op_rank_out,
   input  logic [NUM_RANK_OPS*META_WIDTH-1:0]   op_meta_out,
   output logic [NUM_RANK_OPS-1:0]              op_remove,
   input  logic                                 remove,
   output logic                                 valid_out,
   output logic [RANK_WIDTH-1:0]                rank_out,
   output logic [META_WIDTH-1:0]                meta_out,
   output logic [31:0]                          drop_count
);

   import rank_pkg::*;

   localparam int IN_W  = in_fifo_width(RANK_CODE_BITS, META_WIDTH, FLOW_ID_WIDTH,
                                        FLOW_WEIGHT_WIDTH);
   localparam int OUT_W = out_fifo_width(RANK_WIDTH, META_WIDTH);
   localparam int PTR_W = clog2(NUM_RANK_OPS);

   logic                      op_invalid;
   logic                      drop;
   logic                      in_push;
   logic                      in_pop;
   logic                      in_empty;
   logic                      out_empty;
   logic                      out_nearly_full;
   logic [RANK_CODE_BITS-1:0] wr_op;
   logic [RANK_CODE_BITS-1:0] head_op;
   logic [IN_W-1:0]           in_din;
   logic [IN_W-1:0]           in_dout;
   logic [OUT_W-1:0]          out_din;
   logic [OUT_W-1:0]          out_dout;
   logic [PTR_W-1:0]          rr_ptr;
   logic [PTR_W-1:0]          grant_idx;
   logic                      grant_found;
   logic                      grant;

   // Invalid op codes are resolved before storage so the head op is always in range.
   assign op_invalid = int'(rank_op_in) >= NUM_RANK_OPS;
   assign drop       = insert && op_invalid && (INVALID_OP_MODE == INVALID_DROP);
   assign in_push    = insert && !drop;
   assign wr_op      = op_invalid ? RANK_CODE_BITS'(DEFAULT_OP) : rank_op_in;
   assign in_din     = {wr_op, meta_in, flowID_in, flow_weight_in};

   rank_fifo #(
      .WIDTH    (IN_W),
      .L2_DEPTH (L2_DEPTH)
   ) u_in_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (in_push),
      .pop         (in_pop),
      .din         (in_din),
      .dout        (in_dout),
      .empty       (in_empty),
      .nearly_full (busy)
   );

   assign {head_op, op_meta, op_flowID, op_flow_weight} = in_dout;

   for (genvar k = 0; k < NUM_RANK_OPS; k++) begin : g_dispatch
      assign op_insert[k] = !in_empty && (head_op == RANK_CODE_BITS'(k)) && !op_busy[k];
   end

   assign in_pop = |op_insert;

   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_RANK_OPS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_RANK_OPS) idx = idx - NUM_RANK_OPS;
         if (!grant_found && op_valid_out[PTR_W'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(idx);
         end
      end
   end

   assign grant = grant_found && !out_nearly_full;

   for (genvar k = 0; k < NUM_RANK_OPS; k++) begin : g_collect
      assign op_remove[k] = grant && (grant_idx == PTR_W'(k));
   end

   always_comb begin
      out_din = '0;
      for (int k = 0; k < NUM_RANK_OPS; k++) begin
         if (op_remove[k]) begin
            out_din = {op_rank_out[k*RANK_WIDTH +: RANK_WIDTH],
                       op_meta_out[k*META_WIDTH +: META_WIDTH]};
         end
      end
   end

   rank_fifo #(
      .WIDTH    (OUT_W),
      .L2_DEPTH (L2_DEPTH)
   ) u_out_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (grant),
      .pop         (remove),
      .din         (out_din),
      .dout        (out_dout),
      .empty       (out_empty),
      .nearly_full (out_nearly_full)
   );

   assign valid_out            = !out_empty;
   assign {rank_out, meta_out} = out_dout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr     <= '0;
         drop_count <= '0;
      end else begin
         if (grant) begin
            rr_ptr <= (int'(grant_idx) == NUM_RANK_OPS - 1) ? '0 : grant_idx + PTR_W'(1);
         end
         if (drop && (drop_count != '1)) drop_count <= drop_count + 32'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rank_dispatch.sv
`default_nettype none
// tb_rank_dispatch: directed checks of dispatch, remap/drop, round-robin collect and reset.
// Rev 1.0
module tb_rank_dispatch;

   logic        clk;
   logic        rst;
   logic        insert;
   logic        insert2;
   logic [15:0] meta_in;
   logic [3:0]  rank_op_in;
   logic [15:0] flowID_in;
   logic [7:0]  flow_weight_in;
   logic [3:0]  op_busy;
   logic [3:0]  op_valid_out;
   logic [3:0]  no_valid;
   logic [63:0] op_rank_out;
   logic [63:0] op_meta_out;
   logic        remove;
   logic        remove2;

   logic        busy,        busy2;
   logic [3:0]  op_insert,   op_insert2;
   logic [15:0] op_meta,     op_meta2;
   logic [15:0] op_flowID,   op_flowID2;
   logic [7:0]  op_flow_weight, op_flow_weight2;
   logic [3:0]  op_remove,   op_remove2;
   logic        valid_out,   valid_out2;
   logic [15:0] rank_out,    rank_out2;
   logic [15:0] meta_out,    meta_out2;
   logic [31:0] drop_count,  drop_count2;

   int n_checks;
   int n_fail;
   int grants;

   rank_dispatch #(.INVALID_OP_MODE(0)) dut (
      .clk(clk), .rst(rst), .busy(busy), .insert(insert), .meta_in(meta_in),
      .rank_op_in(rank_op_in), .flowID_in(flowID_in), .flow_weight_in(flow_weight_in),
      .op_busy(op_busy), .op_insert(op_insert), .op_meta(op_meta), .op_flowID(op_flowID),
      .op_flow_weight(op_flow_weight), .op_valid_out(op_valid_out),
      .op_rank_out(op_rank_out), .op_meta_out(op_meta_out), .op_remove(op_remove),
      .remove(remove), .valid_out(valid_out), .rank_out(rank_out), .meta_out(meta_out),
      .drop_count(drop_count)
   );

   rank_dispatch #(.INVALID_OP_MODE(1)) dut_drop (
      .clk(clk), .rst(rst), .busy(busy2), .insert(insert2), .meta_in(meta_in),
      .rank_op_in(rank_op_in), .flowID_in(flowID_in), .flow_weight_in(flow_weight_in),
      .op_busy(op_busy), .op_insert(op_insert2), .op_meta(op_meta2), .op_flowID(op_flowID2),
      .op_flow_weight(op_flow_weight2), .op_valid_out(no_valid),
      .op_rank_out(op_rank_out), .op_meta_out(op_meta_out), .op_remove(op_remove2),
      .remove(remove2), .valid_out(valid_out2), .rank_out(rank_out2), .meta_out(meta_out2),
      .drop_count(drop_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0; n_fail = 0; grants = 0;
      rst = 1'b0; insert = 1'b0; insert2 = 1'b0; remove = 1'b0; remove2 = 1'b0;
      meta_in = '0; rank_op_in = '0; flowID_in = '0; flow_weight_in = '0;
      op_busy = '0; op_valid_out = '0; no_valid = '0;
      op_rank_out = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      op_meta_out = {16'hC003, 16'hC002, 16'hC001, 16'hC000};

      #12;
      check("rst_busy", busy, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_op_insert", op_insert, 0);
      check("rst_op_remove", op_remove, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_rank_out", rank_out, 0);
      check("rst_drop_count2", drop_count2, 0);
      tick; rst = 1'b1;
      tick;

      // Remap of an invalid op to engine 0
      insert = 1'b1; rank_op_in = 4'd2; meta_in = 16'hAAAA; flowID_in = 16'h0101; flow_weight_in = 8'h11;
      tick;
      rank_op_in = 4'd9; meta_in = 16'hBBBB; flowID_in = 16'h0202;
      @(negedge clk);
      check("remap_ins_op2", op_insert, 4'b0100);
      check("remap_meta_op2", op_meta, 16'hAAAA);
      check("remap_flow_op2", op_flowID, 16'h0101);
      tick; insert = 1'b0;
      @(negedge clk);
      check("remap_ins_op9", op_insert, 4'b0001);
      check("remap_meta_op9", op_meta, 16'hBBBB);
      tick;
      @(negedge clk);
      check("remap_idle", op_insert, 0);
      check("remap_drop_count", drop_count, 0);

      // Drop mode counts invalid ops
      tick;
      insert2 = 1'b1; rank_op_in = 4'd15; meta_in = 16'hCCCC;
      for (int i = 0; i < 3; i++) begin
         tick;
         @(negedge clk);
         check("drop_no_insert", op_insert2, 0);
      end
      insert2 = 1'b0;
      check("drop_count_3", drop_count2, 3);
      check("drop_valid_out", valid_out2, 0);
      tick;
      @(negedge clk);
      check("drop_count_hold", drop_count2, 3);

      // Head-of-line blocking
      tick;
      op_busy = 4'b0010;
      insert = 1'b1; rank_op_in = 4'd1; meta_in = 16'h1111;
      tick;
      rank_op_in = 4'd0; meta_in = 16'h2222;
      @(negedge clk);
      check("hol_block_a", op_insert, 0);
      tick; insert = 1'b0;
      @(negedge clk);
      check("hol_block_b", op_insert, 0);
      tick; op_busy = 4'b0000;
      @(negedge clk);
      check("hol_release_op1", op_insert, 4'b0010);
      check("hol_meta_op1", op_meta, 16'h1111);
      tick;
      @(negedge clk);
      check("hol_then_op0", op_insert, 4'b0001);
      check("hol_meta_op0", op_meta, 16'h2222);
      tick;
      @(negedge clk);
      check("hol_empty", op_insert, 0);

      // Round-robin collection
      tick;
      op_valid_out = 4'b1111;
      @(negedge clk);
      check("rr_remove_0", op_remove, 4'b0001);
      check("rr_valid_first", valid_out, 0);
      for (int k = 1; k < 4; k++) begin
         tick;
         @(negedge clk);
         check("rr_remove_k", op_remove, 32'(4'b0001 << k));
         check("rr_valid_k", valid_out, 1);
      end
      tick; op_valid_out = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rr_out_rank", rank_out, 32'h1000 + 32'(k));
         check("rr_out_meta", meta_out, 32'hC000 + 32'(k));
         remove = 1'b1;
         tick; remove = 1'b0;
      end
      @(negedge clk);
      check("rr_drained", valid_out, 0);

      // Output backpressure
      tick;
      op_valid_out = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (op_remove != 4'b0000) grants++;
      end
      check("bp_grants", grants, 15);
      check("bp_stalled", op_remove, 0);
      check("bp_head", rank_out, 16'h1000);
      remove = 1'b1;
      check("bp_stall_on_pop", op_remove, 0);
      tick; remove = 1'b0;
      @(negedge clk);
      check("bp_regrant", op_remove, 4'b0001);
      tick; op_valid_out = 4'b0000;

      // Input FIFO fill up to busy
      op_busy = 4'b1111;
      insert = 1'b1; rank_op_in = 4'd3; meta_in = 16'h3333;
      for (int i = 1; i <= 15; i++) begin
         tick;
         if (i == 15) insert = 1'b0;
         @(negedge clk);
         if (i == 14) check("busy_at_14", busy, 0);
      end
      check("busy_at_15", busy, 1);
      check("busy_no_dispatch", op_insert, 0);

      // Asynchronous reset mid-operation
      check("pre_rst_rr_ptr", 32'(dut.rr_ptr), 1);
      check("pre_rst_drop2", drop_count2, 3);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid_out", valid_out, 0);
      check("arst_busy", busy, 0);
      check("arst_drop_count2", drop_count2, 0);
      check("arst_rr_ptr", 32'(dut.rr_ptr), 0);
      check("arst_rank_out", rank_out, 0);
      check("arst_op_meta", op_meta, 0);
      tick; rst = 1'b1;
      tick;
      @(negedge clk);
      check("post_rst_op_insert", op_insert, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
